multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core. It sequences one shared memory, the instruction register, the register file and the single ALU across several clock cycles per instruction.
- Decodes opcode and funct, then drives every enable and mux select of the multicycle datapath.
- Stretches memory states on a ready handshake.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

Parameters:
- MEM_WAIT_EN, 1, when 0 mem_ready is ignored and treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load, includes the branch qualification (branch & zero)
- reg_write  out  1  register file write
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU A select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- pc_src  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-low.
- Reset:
  - While reset_n=0 at a rising edge, the state register loads FETCH.
  - Every write enable, mem_read, mem_write, instr_done and illegal_op is forced to 0 for as long as reset_n=0.
  - Selects take their FETCH values.
  - Reset asserted mid-instruction aborts it; the next cycle after release is FETCH.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Outputs are Moore decodes of state, except that ir_write, pc_write and instr_done in memory states are qualified by mem_ready.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1, which is also the cycle FETCH advances to DECODE.
  - Otherwise it stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11 (branch target precompute).
  - Next state by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 and no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMREAD for lw and to MEMWRITE for sw.
- MEMREAD:
  - Drives mem_read=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEMWRITE:
  - Drives mem_write=1, i_or_d=1 and holds until mem_ready=1.
  - instr_done is asserted in the cycle mem_ready=1, then -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_write = zero; instr_done=1 -> FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Latency with mem_ready constantly 1:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- R-type funct not in {100000, 100010, 100100, 100101, 101010}: alu_control=010, and the instruction still completes (treated as a no-op write of an add).
- Unused outputs in each state are 0.

Decomposition:
- _const.v gains:
  - opcode macros (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct macros
  - 4-bit state encodings
  - alu_op encodings (00 add, 01 sub, 10 funct)
  - alu_control values
- One sub-module: alu_decoder. It is purely combinational, takes alu_op and funct, and produces alu_control. It is instantiated inside the controller.

Test Plan:
- Reset: reset_n=0 for 3 cycles with mem_ready=1 -> ir_write, pc_write, reg_write, mem_write all 0. First cycle after release: ir_write=1, pc_write=1, alu_src_b=01, alu_control=010.
- addi (opcode 001000), mem_ready=1:
  - States FETCH, DECODE, ADDIEXEC, ADDIWB over 4 cycles.
  - Cycle 4 shows reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - Cycle 5 is FETCH.
- lw (opcode 100011) with mem_ready=0 for 2 cycles in MEMREAD:
  - Instruction takes 7 cycles.
  - reg_write=1 with mem_to_reg=1 only in the MEMWB cycle.
  - mem_read held high for all 3 MEMREAD cycles.
- beq (opcode 000100):
  - zero=1 -> BRANCH cycle shows pc_write=1, pc_src=01, alu_control=110.
  - zero=0 -> pc_write=0.
  - Both cases take 3 cycles.
- R-type sub (funct 100010), then slt (101010) -> EXECUTE shows alu_control=110, then 111. ALUWB shows reg_dst=1, reg_write=1.
- Illegal opcode 111111:
  - DECODE pulses illegal_op=1 for 1 cycle with no writes, then FETCH.
  - Separately, assert reset_n=0 during MEMWRITE with mem_ready=0 -> mem_write=0 from that cycle, and FETCH follows release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM state codes, ALU operation classes and ALU control values.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_CTL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTL_AND = 3'b000;
    localparam logic [2:0] ALU_CTL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTL_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps the controller's operation class and the R-type
// funct field onto the 3-bit ALU control code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_CTL_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_CTL_ADD;
            ALU_OP_SUB: alu_control = ALU_CTL_SUB;
            ALU_OP_FUNCT: begin
                // Unknown functs fall back to add so the instruction still retires.
                case (funct)
                    FUNCT_ADD: alu_control = ALU_CTL_ADD;
                    FUNCT_SUB: alu_control = ALU_CTL_SUB;
                    FUNCT_AND: alu_control = ALU_CTL_AND;
                    FUNCT_OR:  alu_control = ALU_CTL_OR;
                    FUNCT_SLT: alu_control = ALU_CTL_SLT;
                    default:   alu_control = ALU_CTL_ADD;
                endcase
            end
            default: alu_control = ALU_CTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core; sequences shared memory, IR,
// register file and ALU, stretching memory states on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory completes
// DECODE   | register read, branch target precompute, dispatch on opcode
// MEMADR   | compute lw/sw effective address
// MEMREAD  | data read at ALUOut, hold until mem_ready
// MEMWB    | write MDR to rt
// MEMWRITE | data write at ALUOut, hold until mem_ready
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALUOut to rd
// BRANCH   | compare A-B, PC <= ALUOut when zero
// ADDIEXEC | A + signext
// ADDIWB   | write ALUOut to rt
// JUMP     | PC <= jump target
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t  state;
    state_t  next_state;
    alu_op_t alu_op;
    logic    ready;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_OP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = ready;
                if (ready) next_state = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_SUB;
                pc_src     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset kills every enable immediately and parks the selects at FETCH values.
        if (!reset_n) begin
            next_state = S_FETCH;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_src     = 2'b00;
            alu_op     = ALU_OP_ADD;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected output
// vectors are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    typedef struct {
        logic [17:0] v;
        logic        care_ctl;
        string       name;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        int         fetch_wait;
        int         mem_wait;
        logic [2:0] ctl;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [17:0] actual;
    logic [17:0] mask;
    vec_t        vecs[15];

    // Packing order: mr mw iod irw pcw rw rd m2r sa sb[2] pcs[2] ctl[3] done ill
    function automatic logic [17:0] ov(input logic mr, mw, iod, irw, pcw, rw, rd, m2r, sa,
                                       input logic [1:0] sb, pcs, input logic [2:0] ctl,
                                       input logic done, ill);
        return {mr, mw, iod, irw, pcw, rw, rd, m2r, sa, sb, pcs, ctl, done, ill};
    endfunction

    assign actual = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mask = e.care_ctl ? 18'h3ffff : ~18'b11100;
            checks++;
            if ((actual & mask) !== (e.v & mask)) begin
                errors++;
                $display("FAIL %s @%0t: got %b expected %b (mask %b)", e.name, $time, actual, e.v, mask);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic [17:0] v, input logic care, input string nm);
        mem_ready = rdy;
        sb_q.push_back('{v: v, care_ctl: care, name: nm});
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] fetch_v(input logic r);
        return ov(1, 0, 0, r, r, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    endfunction

    function automatic logic [17:0] reset_v();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    endfunction

    task automatic run_instr(input vec_t t);
        logic ill;
        opcode = t.opcode;
        funct  = t.funct;
        zero   = rnd();
        repeat (t.fetch_wait) cyc(0, fetch_v(0), 1, {t.name, ":fetch_wait"});
        cyc(1, fetch_v(1), 1, {t.name, ":fetch"});
        ill = !(t.opcode inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        cyc(rnd(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0, ill), 0, {t.name, ":decode"});
        if (ill) return;
        case (t.opcode)
            6'b100011, 6'b101011: begin
                cyc(rnd(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), 1, {t.name, ":memadr"});
                if (t.opcode == 6'b100011) begin
                    repeat (t.mem_wait)
                        cyc(0, ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0, {t.name, ":memread_wait"});
                    cyc(1, ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0, {t.name, ":memread"});
                    cyc(rnd(), ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0), 0, {t.name, ":memwb"});
                end else begin
                    repeat (t.mem_wait)
                        cyc(0, ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0, {t.name, ":memwrite_wait"});
                    cyc(1, ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0), 0, {t.name, ":memwrite"});
                end
            end
            6'b000000: begin
                cyc(rnd(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, t.ctl, 0, 0), 1, {t.name, ":execute"});
                cyc(rnd(), ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0), 0, {t.name, ":aluwb"});
            end
            6'b000100: begin
                zero = t.zero;
                cyc(rnd(), ov(0, 0, 0, 0, t.zero, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0), 1, {t.name, ":branch"});
            end
            6'b001000: begin
                cyc(rnd(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), 1, {t.name, ":addiexec"});
                cyc(rnd(), ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0), 0, {t.name, ":addiwb"});
            end
            default: begin
                cyc(rnd(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 1, 0), 0, {t.name, ":jump"});
            end
        endcase
    endtask

    initial begin
        vecs[0]  = '{"addi",      6'b001000, 6'b000000, 1'b0, 0, 0, 3'b010};
        vecs[1]  = '{"lw_wait2",  6'b100011, 6'b000000, 1'b0, 0, 2, 3'b010};
        vecs[2]  = '{"beq_taken", 6'b000100, 6'b000000, 1'b1, 0, 0, 3'b110};
        vecs[3]  = '{"beq_not",   6'b000100, 6'b000000, 1'b0, 0, 0, 3'b110};
        vecs[4]  = '{"r_sub",     6'b000000, 6'b100010, 1'b0, 0, 0, 3'b110};
        vecs[5]  = '{"r_slt",     6'b000000, 6'b101010, 1'b0, 0, 0, 3'b111};
        vecs[6]  = '{"r_add",     6'b000000, 6'b100000, 1'b0, 0, 0, 3'b010};
        vecs[7]  = '{"r_and",     6'b000000, 6'b100100, 1'b0, 0, 0, 3'b000};
        vecs[8]  = '{"r_or",      6'b000000, 6'b100101, 1'b0, 0, 0, 3'b001};
        vecs[9]  = '{"r_badfn",   6'b000000, 6'b000111, 1'b0, 0, 0, 3'b010};
        vecs[10] = '{"illegal3f", 6'b111111, 6'b000000, 1'b0, 0, 0, 3'b010};
        vecs[11] = '{"sw_wait",   6'b101011, 6'b000000, 1'b0, 1, 1, 3'b010};
        vecs[12] = '{"jump",      6'b000010, 6'b000000, 1'b0, 0, 0, 3'b010};
        vecs[13] = '{"lw_fwait",  6'b100011, 6'b000000, 1'b0, 2, 0, 3'b010};
        vecs[14] = '{"illegal03", 6'b000011, 6'b000000, 1'b0, 0, 0, 3'b010};

        reset_n   = 1'b0;
        opcode    = 6'b0;
        funct     = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc(1, reset_v(), 1, "reset");
        reset_n = 1'b1;

        foreach (vecs[i]) run_instr(vecs[i]);

        // Reset in the middle of a stalled store: write must drop in the same cycle.
        opcode = 6'b101011;
        cyc(1, fetch_v(1), 1, "rst_sw:fetch");
        cyc(1, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0, 0), 0, "rst_sw:decode");
        cyc(1, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), 1, "rst_sw:memadr");
        cyc(0, ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0, "rst_sw:memwrite");
        reset_n = 1'b0;
        cyc(0, reset_v(), 1, "rst_sw:in_reset");
        cyc(0, reset_v(), 1, "rst_sw:in_reset2");
        reset_n = 1'b1;
        cyc(0, fetch_v(0), 1, "rst_sw:fetch_after");
        run_instr(vecs[12]);
        cyc(0, fetch_v(0), 1, "final_fetch");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
